// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, period/duty changes
// double-buffered to period boundaries, optional per-channel duty slew limit.
module pwm_multi #(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 20,
  parameter int DEFAULT_PERIOD = 1000000,
  parameter int RAMP_STEP      = 0
) (
  input  logic                      CLOCK50,
  input  logic                      RESET_N,
  input  logic                      enable,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      cycle_start,
  output logic [CHANNELS-1:0]       ramping
);

  logic [CHANNELS-1:0][WIDTH-1:0] duty_lanes;
  logic [CHANNELS-1:0][WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic [CHANNELS-1:0][WIDTH-1:0] tgt_duty_q, tgt_duty_d;
  logic [CHANNELS-1:0][WIDTH-1:0] cur_duty_q, cur_duty_d;
  logic [CHANNELS-1:0]            pwm_out_q, pwm_out_d;
  logic [CHANNELS-1:0]            ramping_q, ramping_d;
  logic [WIDTH-1:0]               cnt_q, cnt_d;
  logic [WIDTH-1:0]               act_period_q, act_period_d;
  logic [WIDTH-1:0]               pend_period_q, pend_period_d;
  logic                           pending_valid_q, pending_valid_d;
  logic                           cycle_start_q, cycle_start_d;
  logic                           boundary, apply;

  assign duty_lanes = duty;

  // Step one RAMP_STEP toward tgt; compared at WIDTH+1 bits so the step
  // never wraps past either end of the range.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0] cur_x, tgt_x, step_x;
    cur_x  = {1'b0, cur};
    tgt_x  = {1'b0, tgt};
    step_x = (WIDTH+1)'(RAMP_STEP);
    step_toward = tgt;
    if (RAMP_STEP != 0) begin
      if (tgt_x > cur_x) begin
        if (tgt_x - cur_x > step_x) step_toward = WIDTH'(cur_x + step_x);
      end else if (cur_x - tgt_x > step_x) begin
        step_toward = WIDTH'(cur_x - step_x);
      end
    end
  endfunction

  assign boundary = enable && (cnt_q == act_period_q - WIDTH'(1));
  // A load coincident with the boundary sees pending_valid_q of the old
  // contents only, so its values wait for the following boundary.
  assign apply    = boundary && pending_valid_q;

  always_comb begin
    cnt_d = '0;
    if (enable && !boundary) cnt_d = cnt_q + WIDTH'(1);
    act_period_d  = apply ? pend_period_q : act_period_q;
    pend_period_d = pend_period_q;
    if (load) pend_period_d = (period < WIDTH'(2)) ? WIDTH'(2) : period;
    pending_valid_d = load ? 1'b1 : (apply ? 1'b0 : pending_valid_q);
    cycle_start_d   = enable && (cnt_q == '0);
    for (int i = 0; i < CHANNELS; i++) begin
      pend_duty_d[i] = load ? duty_lanes[i] : pend_duty_q[i];
      tgt_duty_d[i]  = apply ? pend_duty_q[i] : tgt_duty_q[i];
      cur_duty_d[i]  = '0;
      if (enable)
        cur_duty_d[i] = boundary ? step_toward(cur_duty_q[i], tgt_duty_d[i]) : cur_duty_q[i];
      pwm_out_d[i] = enable && (cnt_q < cur_duty_q[i]);
      ramping_d[i] = (cur_duty_q[i] != tgt_duty_q[i]);
    end
  end

  always_ff @(posedge CLOCK50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q           <= '0;
      act_period_q    <= WIDTH'(DEFAULT_PERIOD);
      pend_period_q   <= WIDTH'(DEFAULT_PERIOD);
      pending_valid_q <= 1'b0;
      cycle_start_q   <= 1'b0;
      pend_duty_q     <= '0;
      tgt_duty_q      <= '0;
      cur_duty_q      <= '0;
      pwm_out_q       <= '0;
      ramping_q       <= '0;
    end else begin
      cnt_q           <= cnt_d;
      act_period_q    <= act_period_d;
      pend_period_q   <= pend_period_d;
      pending_valid_q <= pending_valid_d;
      cycle_start_q   <= cycle_start_d;
      pend_duty_q     <= pend_duty_d;
      tgt_duty_q      <= tgt_duty_d;
      cur_duty_q      <= cur_duty_d;
      pwm_out_q       <= pwm_out_d;
      ramping_q       <= ramping_d;
    end
  end

  assign pwm_out     = pwm_out_q;
  assign cycle_start = cycle_start_q;
  assign ramping     = ramping_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: WIDTH=8, period 10, one instance without and
// one with a duty slew limit of 2.
module tb_pwm_multi;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, en, ld;
  logic [W-1:0]   per;
  logic [2*W-1:0] dty;
  logic [1:0]     pwm, rmp;
  logic           cs;

  logic           r_rst_n, r_en, r_ld;
  logic [W-1:0]   r_per;
  logic [2*W-1:0] r_dty;
  logic [1:0]     r_pwm, r_rmp;
  logic           r_cs;

  int checks = 0;
  int errors = 0;

  pwm_multi #(.CHANNELS(2), .WIDTH(W), .DEFAULT_PERIOD(10), .RAMP_STEP(0)) dut (
    .CLOCK50(clk), .RESET_N(rst_n), .enable(en), .load(ld), .period(per),
    .duty(dty), .pwm_out(pwm), .cycle_start(cs), .ramping(rmp));

  pwm_multi #(.CHANNELS(2), .WIDTH(W), .DEFAULT_PERIOD(10), .RAMP_STEP(2)) dut_r (
    .CLOCK50(clk), .RESET_N(r_rst_n), .enable(r_en), .load(r_ld), .period(r_per),
    .duty(r_dty), .pwm_out(r_pwm), .cycle_start(r_cs), .ramping(r_rmp));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for cycle_start, then sample n cycles of one period; leaves the bench
  // on the sample right after that period.
  task automatic measure(input bit sel, input int n, output int w, output int h0, output int h1,
                         output bit shape_ok, output int cs_extra, output logic [1:0] mid_rmp);
    logic [1:0] p, prev;
    w = 0; h0 = 0; h1 = 0; shape_ok = 1'b1; cs_extra = 0; mid_rmp = '0; prev = 2'b11;
    while (!(sel ? r_cs : cs) && w < 60) begin
      tick();
      w++;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        tick();
        if (sel ? r_cs : cs) cs_extra++;
      end
      p = sel ? r_pwm : pwm;
      for (int c = 0; c < 2; c++) if (p[c] && !prev[c]) shape_ok = 1'b0;
      h0 += int'(p[0]);
      h1 += int'(p[1]);
      if (i == n / 2) mid_rmp = sel ? r_rmp : rmp;
      prev = p;
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ld = 1'b0; per = '0; dty = '0;
    r_rst_n = 1'b0; r_en = 1'b0; r_ld = 1'b0; r_per = '0; r_dty = '0;
    repeat (2) tick();
    checks++; if (pwm !== 2'b00) begin errors++; $display("FAIL reset_pwm: got %b exp 00", pwm); end
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b exp 0", cs); end
    checks++; if (rmp !== 2'b00) begin errors++; $display("FAIL reset_ramping: got %b exp 00", rmp); end
    checks++; if (r_pwm !== 2'b00) begin errors++; $display("FAIL reset_r_pwm: got %b exp 00", r_pwm); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL disabled_cs: got %b exp 0", cs); end
  endtask

  task automatic test_basic();
    int w, h0, h1, cx; bit sh; logic [1:0] mr;
    en = 1'b1; ld = 1'b1; per = 8'd10; dty = {8'd7, 8'd4};
    tick();
    ld = 1'b0;
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (w !== 0) begin errors++; $display("FAIL basic_first_cs_wait: got %0d exp 0", w); end
    checks++; if (h0 + h1 !== 0) begin errors++; $display("FAIL basic_pre_boundary_high: got %0d exp 0", h0 + h1); end
    for (int k = 0; k < 2; k++) begin
      measure(1'b0, 10, w, h0, h1, sh, cx, mr);
      checks++; if (w !== 0) begin errors++; $display("FAIL basic_period_len[%0d]: wait %0d exp 0", k, w); end
      checks++; if (h0 !== 4) begin errors++; $display("FAIL basic_h0[%0d]: got %0d exp 4", k, h0); end
      checks++; if (h1 !== 7) begin errors++; $display("FAIL basic_h1[%0d]: got %0d exp 7", k, h1); end
      checks++; if (cx !== 0) begin errors++; $display("FAIL basic_cs_extra[%0d]: got %0d exp 0", k, cx); end
      checks++; if (sh !== 1'b1) begin errors++; $display("FAIL basic_shape[%0d]: got %b exp 1", k, sh); end
    end
    checks++; if (rmp !== 2'b00) begin errors++; $display("FAIL basic_ramping: got %b exp 00", rmp); end
  endtask

  task automatic test_mid_load();
    int w, h0, h1, cx; bit sh; logic [1:0] mr;
    w = 0;
    while (!cs && w < 60) begin tick(); w++; end
    checks++; if (w >= 60) begin errors++; $display("FAIL mid_wait: got timeout exp cycle_start"); end
    h0 = 0; h1 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      ld = (i == 4);
      if (i == 4) dty = {8'd7, 8'd2};
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
    checks++; if (h0 !== 4) begin errors++; $display("FAIL mid_current_h0: got %0d exp 4", h0); end
    checks++; if (h1 !== 7) begin errors++; $display("FAIL mid_current_h1: got %0d exp 7", h1); end
    tick();
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (w !== 0) begin errors++; $display("FAIL mid_next_wait: got %0d exp 0", w); end
    checks++; if (h0 !== 2) begin errors++; $display("FAIL mid_next_h0: got %0d exp 2", h0); end
    checks++; if (sh !== 1'b1) begin errors++; $display("FAIL mid_next_shape: got %b exp 1", sh); end
  endtask

  task automatic test_boundaries();
    int w, h0, h1, cx; bit sh; logic [1:0] mr;
    ld = 1'b1; dty = {8'd10, 8'd0}; tick(); ld = 1'b0;
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (h0 !== 0) begin errors++; $display("FAIL bnd_duty0: got %0d exp 0", h0); end
    checks++; if (h1 !== 10) begin errors++; $display("FAIL bnd_duty_eq_period: got %0d exp 10", h1); end
    ld = 1'b1; dty = {8'd0, 8'd200}; tick(); ld = 1'b0;
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (h0 !== 10) begin errors++; $display("FAIL bnd_duty200: got %0d exp 10", h0); end
    checks++; if (h1 !== 0) begin errors++; $display("FAIL bnd_duty0_ch1: got %0d exp 0", h1); end
    ld = 1'b1; per = 8'd1; dty = {8'd1, 8'd1}; tick(); ld = 1'b0;
    measure(1'b0, 2, w, h0, h1, sh, cx, mr);
    checks++; if (w >= 60) begin errors++; $display("FAIL bnd_p2_wait: got timeout exp cycle_start"); end
    measure(1'b0, 2, w, h0, h1, sh, cx, mr);
    checks++; if (w !== 0) begin errors++; $display("FAIL bnd_period_clamp2: wait %0d exp 0", w); end
    checks++; if (h0 !== 1 || h1 !== 1) begin errors++; $display("FAIL bnd_p2_high: got %0d/%0d exp 1/1", h0, h1); end
    // cnt_q=1 is the boundary of a period-2 cycle: this load waits one more period
    ld = 1'b1; per = 8'd10; dty = {8'd7, 8'd4}; tick(); ld = 1'b0;
    measure(1'b0, 2, w, h0, h1, sh, cx, mr);
    checks++; if (w !== 1) begin errors++; $display("FAIL bnd_coincident_wait: got %0d exp 1", w); end
    checks++; if (h0 !== 1 || h1 !== 1) begin errors++; $display("FAIL bnd_coincident_old: got %0d/%0d exp 1/1", h0, h1); end
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (w !== 0 || h0 !== 4 || h1 !== 7) begin
      errors++; $display("FAIL bnd_coincident_new: wait %0d high %0d/%0d exp 0 4/7", w, h0, h1);
    end
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (w !== 0 || cx !== 0) begin errors++; $display("FAIL bnd_period10: wait %0d extra %0d exp 0 0", w, cx); end
  endtask

  task automatic test_ramp();
    int w, h0, h1, cx; bit sh; logic [1:0] mr;
    int exp_h[5] = '{0, 2, 4, 6, 7};
    logic exp_r[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    r_rst_n = 1'b1; r_en = 1'b1; r_ld = 1'b1; r_per = 8'd10; r_dty = {8'd0, 8'd7};
    tick();
    r_ld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      measure(1'b1, 10, w, h0, h1, sh, cx, mr);
      checks++; if (w !== 0) begin errors++; $display("FAIL ramp_wait[%0d]: got %0d exp 0", k, w); end
      checks++; if (h0 !== exp_h[k]) begin errors++; $display("FAIL ramp_h0[%0d]: got %0d exp %0d", k, h0, exp_h[k]); end
      checks++; if (h1 !== 0) begin errors++; $display("FAIL ramp_h1[%0d]: got %0d exp 0", k, h1); end
      checks++; if (mr !== {1'b0, exp_r[k]}) begin
        errors++; $display("FAIL ramp_ramping[%0d]: got %b exp %b", k, mr, {1'b0, exp_r[k]});
      end
    end
  endtask

  task automatic test_enable();
    int w, h0, h1, cx; bit sh; logic [1:0] mr;
    tick(); tick();
    checks++; if (pwm !== 2'b11) begin errors++; $display("FAIL en_before_drop: got %b exp 11", pwm); end
    en = 1'b0;
    tick();
    checks++; if (pwm !== 2'b00) begin errors++; $display("FAIL en_drop_pwm: got %b exp 00", pwm); end
    repeat (3) tick();
    checks++; if (pwm !== 2'b00 || cs !== 1'b0) begin errors++; $display("FAIL en_idle: pwm %b cs %b exp 00 0", pwm, cs); end
    en = 1'b1;
    tick();
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL en_restart_cs: got %b exp 1", cs); end
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (w !== 0 || h0 !== 0 || h1 !== 0) begin
      errors++; $display("FAIL en_first_period: wait %0d high %0d/%0d exp 0 0/0", w, h0, h1);
    end
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (w !== 0 || h0 !== 4 || h1 !== 7) begin
      errors++; $display("FAIL en_second_period: wait %0d high %0d/%0d exp 0 4/7", w, h0, h1);
    end
  endtask

  task automatic test_reset_mid();
    int w, h0, h1, cx; bit sh; logic [1:0] mr;
    checks++; if (pwm !== 2'b11) begin errors++; $display("FAIL rst_mid_pre: got %b exp 11", pwm); end
    rst_n = 1'b0;
    #1;
    checks++; if (pwm !== 2'b00) begin errors++; $display("FAIL rst_mid_async_pwm: got %b exp 00", pwm); end
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL rst_mid_async_cs: got %b exp 0", cs); end
    tick(); tick();
    rst_n = 1'b1;
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (w >= 60) begin errors++; $display("FAIL rst_mid_wait: got timeout exp cycle_start"); end
    checks++; if (h0 + h1 !== 0) begin errors++; $display("FAIL rst_mid_low1: got %0d exp 0", h0 + h1); end
    measure(1'b0, 10, w, h0, h1, sh, cx, mr);
    checks++; if (w !== 0) begin errors++; $display("FAIL rst_mid_period10: wait %0d exp 0", w); end
    checks++; if (h0 + h1 !== 0) begin errors++; $display("FAIL rst_mid_low2: got %0d exp 0", h0 + h1); end
    checks++; if (rmp !== 2'b00) begin errors++; $display("FAIL rst_mid_ramping: got %b exp 00", rmp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_load();
    test_boundaries();
    test_ramp();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel, parametrised PWM generator for motor and servo drive.
- All channels share one period counter.
- Period and duty changes are double-buffered and applied only at period boundaries, so output edges stay glitch-free.
- Optional per-channel duty slew limit (soft-start) protects the motors against step changes from the line-following controller.

Parameters:
- CHANNELS, 2, number of PWM outputs.
- WIDTH, 20, width of the counter, period and duty values.
- DEFAULT_PERIOD, 1000000, period in clocks after reset (50 Hz at 50 MHz).
- RAMP_STEP, 0, maximum duty change per period per channel; 0 means changes apply immediately.

Ports:
- CLOCK50  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous active-low reset.
- enable  in  1  run/stop for all channels.
- load  in  1  single-cycle strobe that captures period and duty into the pending registers.
- period  in  WIDTH  requested period in clocks.
- duty  in  CHANNELS*WIDTH  requested high time in clocks, one field per channel; channel i occupies bits [i*WIDTH +: WIDTH].
- pwm_out  out  CHANNELS  registered PWM outputs.
- cycle_start  out  1  one-cycle pulse at the start of each period.
- ramping  out  CHANNELS  high while a channel's current duty differs from its target duty.

Behaviour:
- Reset (async, RESET_N=0):
  - cnt=0; act_period=DEFAULT_PERIOD.
  - cur_duty[i]=0; tgt_duty[i]=0; pending_valid=0.
  - pwm_out=0; cycle_start=0; ramping=0.
  - Reset asserted mid-period aborts the period immediately; no partial pulse completes.
- Load:
  - load=1 captures period and duty into the pending registers and sets pending_valid.
  - A later load before the boundary overwrites the pending registers; the last load wins.
  - Pending period is clamped to a minimum of 2 on capture.
- Counter:
  - While enable=1: cnt increments each clock and wraps from act_period-1 to 0.
  - Boundary is the cycle where cnt==act_period-1.
- At a boundary (registered, effective from the cnt=0 cycle):
  - If pending_valid: act_period<=pend_period, tgt_duty<=pend_duty, pending_valid<=0.
  - Each cur_duty[i] then steps toward the updated tgt_duty[i]:
    - RAMP_STEP=0: cur<=tgt.
    - |tgt-cur|<=RAMP_STEP: cur<=tgt.
    - Otherwise: cur<=cur±RAMP_STEP.
  - Step arithmetic is done at WIDTH+1 bits and never over- or underflows.
- load coincident with a boundary: pending is captured, but the values are applied at the following boundary, not this one.
- Output (1-cycle latency):
  - pwm_out[i]<=enable && (cnt<cur_duty[i]).
  - cur_duty=0 gives constant low.
  - cur_duty>=act_period gives constant high for the whole period.
- cycle_start: registered pulse of exactly one clock, aligned with the pwm_out cycle that reflects cnt==0.
- ramping[i]: registered (cur_duty[i]!=tgt_duty[i]).
- enable deassert:
  - Next clock: pwm_out=0, cnt held at 0, cur_duty cleared to 0, cycle_start suppressed.
  - tgt_duty, act_period and the pending registers are retained.
  - load is still accepted while disabled.
- enable assert: the counter starts at 0 on the next clock, so the first period is complete; duty ramps from 0 toward the target.
- Duty is applied to the output only when it changes at a period boundary, never mid-period, even if load arrives mid-period.

Test Plan:
1. Reset defaults; WIDTH=8, DEFAULT_PERIOD=10, RAMP_STEP=0; enable=1, load period=10, duty=4/7 -> pwm_out[0] high 4 of every 10 clocks and pwm_out[1] high 7 of every 10, starting at the first boundary after load; cycle_start every 10 clocks.
2. Mid-period load of duty=2 while duty=4 is active, load at cnt=5 -> current period completes at 4 high; next period is 2 high; no glitch.
3. Boundaries: duty=0 -> constant low; duty=10 and duty=200 with period=10 -> constant high; load period=1 -> act_period=2.
4. RAMP_STEP=2, target 0->7, period=10 -> high times per period are 2,4,6,7; ramping is high for 3 periods, then low.
5. enable drops at cnt=3 -> pwm_out=0 the next clock; re-enable -> cnt restarts at 0 and duty re-ramps from 0.
6. RESET_N pulsed low mid-period with pwm_out high -> pwm_out=0 asynchronously; after release, period=10 and all outputs stay low until a new load.
